// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, bin_in   conversion request and the unsigned value captured with it
//   unidades..milesimas  BCD digits, updated only when a conversion finishes
//   listo           result valid, held until the next accepted start
//   ocupado         conversion in progress (start ignored while high)
//   desborde        last result saturated to 9999 because bin_in exceeded MAX_VAL
module bin_to_bcd_seq #(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    output logic [3:0]       unidades,
    output logic [3:0]       decenas,
    output logic [3:0]       centenas,
    output logic [3:0]       milesimas,
    output logic             listo,
    output logic             ocupado,
    output logic             desborde
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [31:0] MAXV = 32'(MAX_VAL);
    typedef enum logic [1:0] {IDLE, CONV, FIN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] sr;
    logic [15:0] scr;
    logic [15:0] adj;
    logic [CW-1:0] cnt;
    logic ovf;
    // add-3 correction applied to every scratch nibble before the shift
    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign adj[4*i+:4] = (scr[4*i+:4] >= 4'd5) ? scr[4*i+:4] + 4'd3 : scr[4*i+:4];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            scr       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            unidades  <= '0;
            decenas   <= '0;
            centenas  <= '0;
            milesimas <= '0;
            listo     <= 1'b0;
            ocupado   <= 1'b0;
            desborde  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    sr      <= bin_in;
                    scr     <= '0;
                    ovf     <= 32'(bin_in) > MAXV;
                    cnt     <= CNT_INIT;
                    listo   <= 1'b0;
                    ocupado <= 1'b1;
                    state   <= CONV;
                end
                CONV: begin
                    {scr, sr} <= {adj[14:0], sr, 1'b0};
                    if (cnt == '0) state <= FIN;
                    else cnt <= cnt - CW'(1);
                end
                FIN: begin
                    {milesimas, centenas, decenas, unidades} <= ovf ? 16'h9999 : scr;
                    desborde <= ovf;
                    listo    <= 1'b1;
                    ocupado  <= 1'b0;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
